// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with encoded owner index and registered one-hot decode.
// Ownership ends on release, owner drop, or after MAX_HOLD consecutive grant cycles.
module rr_decode_arbiter #(
    parameter int unsigned N_REQ    = 8,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               vld_q, vld_d;
    logic               timeout_q, timeout_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   cand;
    logic               owner_done;
    logic               at_limit;

    // First set request at or after ptr; index arithmetic wraps 7->0 naturally.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign owner_done = rel || !req[idx_q];
    assign at_limit   = (hold_q == CNT_W'(MAX_HOLD));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    idx_d   = win;
                    gnt_d   = N_REQ'(1) << win;
                    vld_d   = 1'b1;
                    hold_d  = CNT_W'(1);
                end
            end
            StGrant: begin
                if (owner_done || at_limit) begin
                    state_d   = StIdle;
                    gnt_d     = '0;
                    vld_d     = 1'b0;
                    ptr_d     = idx_q + IDX_W'(1);
                    hold_d    = '0;
                    // A release or owner drop on the limit cycle is not a timeout.
                    timeout_d = !owner_done;
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign timeout = timeout_q;

endmodule
